// File: rtl/ascon_arbiter.sv
// Round-robin arbiter and sequencer that shares one ASCON core between two requesters.
// It latches the owner's key/nonce, streams its blocks and routes the responses back to it.
module ascon_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic [1:0]        req_i,
  input  logic [1:0][127:0] key_i,
  input  logic [1:0][127:0] nonce_i,
  input  logic [1:0][3:0]   nblk_i,
  input  logic [1:0][63:0]  data_i,
  input  logic [1:0]        data_valid_i,
  output logic [1:0]        grant_o,
  output logic [1:0]        data_ready_o,
  output logic [1:0]        cipher_valid_o,
  output logic [63:0]       cipher_o,
  output logic [127:0]      tag_o,
  output logic [1:0]        done_o,
  output logic [1:0]        err_o,
  output logic              core_start_o,
  output logic [127:0]      core_key_o,
  output logic [127:0]      core_nonce_o,
  output logic              core_data_valid_o,
  output logic [63:0]       core_data_o,
  input  logic              core_cipher_valid_i,
  input  logic [63:0]       core_cipher_i,
  input  logic              core_end_i,
  input  logic [127:0]      core_tag_i
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DATA,
    WAIT_CIPHER,
    WAIT_END
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       owner;
  logic       last_grant;
  logic       sel;
  logic [3:0] cnt;
  logic [7:0] wdog;
  logic       wdog_hit;
  logic [1:0] owner_oh;
  logic       do_grant;
  logic       do_accept;
  logic       do_cipher;
  logic       do_done;
  logic       do_abort;

  assign owner_oh = {owner, ~owner};
  // The abort is registered, so it is decided one count early to land exactly TIMEOUT cycles in.
  assign wdog_hit = (wdog == 8'(TIMEOUT - 1));

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel       = 1'b0;
    do_grant  = 1'b0;
    do_accept = 1'b0;
    do_cipher = 1'b0;
    do_done   = 1'b0;
    do_abort  = 1'b0;
    case (state)
      IDLE: begin
        if (req_i != 2'b00) begin
          do_grant  = 1'b1;
          sel       = (req_i == 2'b11) ? ~last_grant : req_i[1];
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = (cnt != 4'd0) ? WAIT_DATA : WAIT_END;
      end
      WAIT_DATA: begin
        if (core_end_i) begin
          do_abort = 1'b1;
        end else if (data_valid_i[owner]) begin
          do_accept = 1'b1;
          state_nxt = WAIT_CIPHER;
        end
      end
      WAIT_CIPHER: begin
        if (core_end_i) begin
          do_abort = 1'b1;
        end else if (core_cipher_valid_i) begin
          do_cipher = 1'b1;
          state_nxt = (cnt == 4'd1) ? WAIT_END : WAIT_DATA;
        end else if (wdog_hit) begin
          do_abort = 1'b1;
        end
      end
      WAIT_END: begin
        if (core_cipher_valid_i) begin
          do_abort = 1'b1;
        end else if (core_end_i) begin
          do_done = 1'b1;
        end else if (wdog_hit) begin
          do_abort = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (do_done || do_abort) begin
      state_nxt = IDLE;
    end
  end

  // Transaction bookkeeping: owner, fairness pointer, block count and watchdog.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      wdog       <= 8'd0;
    end else begin
      if (do_grant) begin
        owner <= sel;
        cnt   <= nblk_i[sel];
      end else if (do_cipher) begin
        cnt <= cnt - 4'd1;
      end
      if (do_done || do_abort) begin
        last_grant <= owner;
      end
      if (state_nxt != state) begin
        wdog <= 8'd0;
      end else if (state == WAIT_CIPHER || state == WAIT_END) begin
        wdog <= wdog + 8'd1;
      end
    end
  end

  // Registered outputs toward the requesters and the core.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      grant_o           <= 2'b00;
      data_ready_o      <= 2'b00;
      cipher_valid_o    <= 2'b00;
      cipher_o          <= 64'd0;
      tag_o             <= 128'd0;
      done_o            <= 2'b00;
      err_o             <= 2'b00;
      core_start_o      <= 1'b0;
      core_key_o        <= 128'd0;
      core_nonce_o      <= 128'd0;
      core_data_valid_o <= 1'b0;
      core_data_o       <= 64'd0;
    end else begin
      core_start_o      <= do_grant;
      core_data_valid_o <= do_accept;
      cipher_valid_o    <= do_cipher ? owner_oh : 2'b00;
      done_o            <= do_done ? owner_oh : 2'b00;
      err_o             <= do_abort ? owner_oh : 2'b00;
      data_ready_o      <= (state_nxt == WAIT_DATA) ? owner_oh : 2'b00;
      if (do_grant) begin
        grant_o      <= sel ? 2'b10 : 2'b01;
        core_key_o   <= key_i[sel];
        core_nonce_o <= nonce_i[sel];
      end else if (do_done || do_abort) begin
        grant_o <= 2'b00;
      end
      if (do_accept) begin
        core_data_o <= data_i[owner];
      end
      if (do_cipher) begin
        cipher_o <= core_cipher_i;
      end
      if (do_done) begin
        tag_o <= core_tag_i;
      end
    end
  end

endmodule

// File: tb/tb_ascon_arbiter.sv
// Directed bench for ascon_arbiter: a table of per-cycle stimulus and expected strobes,
// followed by a hand-written asynchronous reset sequence.
module tb_ascon_arbiter;

  logic              clock_i;
  logic              resetb_i;
  logic [1:0]        req_i;
  logic [1:0][127:0] key_i;
  logic [1:0][127:0] nonce_i;
  logic [1:0][3:0]   nblk_i;
  logic [1:0][63:0]  data_i;
  logic [1:0]        data_valid_i;
  logic [1:0]        grant_o;
  logic [1:0]        data_ready_o;
  logic [1:0]        cipher_valid_o;
  logic [63:0]       cipher_o;
  logic [127:0]      tag_o;
  logic [1:0]        done_o;
  logic [1:0]        err_o;
  logic              core_start_o;
  logic [127:0]      core_key_o;
  logic [127:0]      core_nonce_o;
  logic              core_data_valid_o;
  logic [63:0]       core_data_o;
  logic              core_cipher_valid_i;
  logic [63:0]       core_cipher_i;
  logic              core_end_i;
  logic [127:0]      core_tag_i;

  ascon_arbiter #(.TIMEOUT(8)) dut (
    .clock_i             (clock_i),
    .resetb_i            (resetb_i),
    .req_i               (req_i),
    .key_i               (key_i),
    .nonce_i             (nonce_i),
    .nblk_i              (nblk_i),
    .data_i              (data_i),
    .data_valid_i        (data_valid_i),
    .grant_o             (grant_o),
    .data_ready_o        (data_ready_o),
    .cipher_valid_o      (cipher_valid_o),
    .cipher_o            (cipher_o),
    .tag_o               (tag_o),
    .done_o              (done_o),
    .err_o               (err_o),
    .core_start_o        (core_start_o),
    .core_key_o          (core_key_o),
    .core_nonce_o        (core_nonce_o),
    .core_data_valid_o   (core_data_valid_o),
    .core_data_o         (core_data_o),
    .core_cipher_valid_i (core_cipher_valid_i),
    .core_cipher_i       (core_cipher_i),
    .core_end_i          (core_end_i),
    .core_tag_i          (core_tag_i)
  );

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [3:0] n0;
    logic [3:0] n1;
    logic [1:0] dv;
    logic       cv;
    logic       ce;
    logic [1:0] g;
    logic       st;
    logic [1:0] dr;
    logic       cdv;
    logic [1:0] cvl;
    logic [1:0] dn;
    logic [1:0] er;
  } vec_t;

  vec_t         vecs[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] cur_key   [2];
  logic [127:0] cur_nonce [2];
  logic [63:0]  cur_data  [2];
  logic [63:0]  cur_ciph;
  logic [127:0] cur_tag;
  logic [127:0] exp_key;
  logic [127:0] exp_nonce;

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic add_vec(input logic rst, input logic [1:0] req, input logic [3:0] n0,
                         input logic [3:0] n1, input logic [1:0] dv, input logic cv,
                         input logic ce, input logic [1:0] g, input logic st,
                         input logic [1:0] dr, input logic cdv, input logic [1:0] cvl,
                         input logic [1:0] dn, input logic [1:0] er);
    vec_t v;
    v.rst = rst; v.req = req; v.n0 = n0; v.n1 = n1; v.dv = dv; v.cv = cv; v.ce = ce;
    v.g = g; v.st = st; v.dr = dr; v.cdv = cdv; v.cvl = cvl; v.dn = dn; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check_val({name, " strobes"}, 128'({grant_o, core_start_o, data_ready_o, core_data_valid_o,
                                         cipher_valid_o, done_o, err_o}), 128'd0);
    check_val({name, " buses"}, 128'(|{cipher_o, tag_o, core_key_o, core_nonce_o, core_data_o}),
              128'd0);
  endtask

  task automatic apply_stimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clock_i);
    if (v.rst) begin
      resetb_i = 1'b0;
      #1;
      resetb_i = 1'b1;
    end
    for (int r = 0; r < 2; r++) begin
      cur_key[r]   = {32'(r), 64'h0123_4567_89AB_CDEF, 32'(idx)};
      cur_nonce[r] = ~cur_key[r];
      cur_data[r]  = {32'hDA7A_0000 ^ 32'(r), 32'(idx)};
      key_i[r]     = cur_key[r];
      nonce_i[r]   = cur_nonce[r];
      data_i[r]    = cur_data[r];
    end
    cur_ciph            = {32'hC1F0_0000, 32'(idx)};
    cur_tag             = {96'h7A6_0000_0000_0000_0000_0000, 32'(idx)};
    core_cipher_i       = cur_ciph;
    core_tag_i          = cur_tag;
    req_i               = v.req;
    nblk_i[0]           = v.n0;
    nblk_i[1]           = v.n1;
    data_valid_i        = v.dv;
    core_cipher_valid_i = v.cv;
    core_end_i          = v.ce;
    @(posedge clock_i);
    #1;
    check_output(idx, v);
  endtask

  task automatic check_output(input int idx, input vec_t v);
    check_val($sformatf("row%0d strobes", idx),
              128'({grant_o, core_start_o, data_ready_o, core_data_valid_o,
                    cipher_valid_o, done_o, err_o}),
              128'({v.g, v.st, v.dr, v.cdv, v.cvl, v.dn, v.er}));
    if (v.st) begin
      exp_key   = cur_key[v.g[1]];
      exp_nonce = cur_nonce[v.g[1]];
    end
    if (v.g != 2'b00) begin
      check_val($sformatf("row%0d core_key", idx), core_key_o, exp_key);
      check_val($sformatf("row%0d core_nonce", idx), core_nonce_o, exp_nonce);
    end
    if (v.cdv) check_val($sformatf("row%0d core_data", idx), 128'(core_data_o), 128'(cur_data[v.dv[1]]));
    if (v.cvl != 2'b00) check_val($sformatf("row%0d cipher", idx), 128'(cipher_o), 128'(cur_ciph));
    if (v.dn != 2'b00) check_val($sformatf("row%0d tag", idx), tag_o, cur_tag);
  endtask

  initial begin
    resetb_i = 1'b1;
    req_i = 2'b00; key_i = '0; nonce_i = '0; nblk_i = '0; data_i = '0; data_valid_i = 2'b00;
    core_cipher_valid_i = 1'b0; core_cipher_i = 64'd0; core_end_i = 1'b0; core_tag_i = 128'd0;
    exp_key = 128'd0; exp_nonce = 128'd0;

    // Single request from requester 0 with two blocks
    add_vec(1, 2'b01, 2, 0, 2'b00, 0, 0,  2'b01, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 2, 0, 2'b00, 0, 0,  2'b01, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 2, 0, 2'b01, 0, 0,  2'b01, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 2, 0, 2'b00, 0, 0,  2'b01, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 2, 0, 2'b00, 1, 0,  2'b01, 0, 2'b01, 0, 2'b01, 2'b00, 2'b00);
    add_vec(0, 2'b01, 2, 0, 2'b01, 0, 0,  2'b01, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 2, 0, 2'b00, 1, 0,  2'b01, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00);
    add_vec(0, 2'b01, 2, 0, 2'b00, 0, 0,  2'b01, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 2, 0, 2'b00, 0, 1,  2'b00, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00);
    add_vec(0, 2'b00, 0, 0, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    // Tie from reset: 0, then 1, then 0 again (with nblk=0)
    add_vec(1, 2'b11, 1, 1, 2'b00, 0, 0,  2'b01, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b11, 1, 1, 2'b00, 0, 0,  2'b01, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b11, 1, 1, 2'b01, 0, 0,  2'b01, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b11, 1, 1, 2'b00, 1, 0,  2'b01, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00);
    add_vec(0, 2'b11, 1, 1, 2'b00, 0, 1,  2'b00, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00);
    add_vec(0, 2'b11, 1, 1, 2'b00, 0, 0,  2'b10, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b11, 1, 1, 2'b00, 0, 0,  2'b10, 0, 2'b10, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b11, 1, 1, 2'b10, 0, 0,  2'b10, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b11, 1, 1, 2'b00, 1, 0,  2'b10, 0, 2'b00, 0, 2'b10, 2'b00, 2'b00);
    add_vec(0, 2'b11, 1, 1, 2'b00, 0, 1,  2'b00, 0, 2'b00, 0, 2'b00, 2'b10, 2'b00);
    add_vec(0, 2'b11, 0, 1, 2'b00, 0, 0,  2'b01, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 0, 1, 2'b00, 0, 0,  2'b01, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 0, 1, 2'b00, 0, 0,  2'b01, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 0, 1, 2'b00, 0, 1,  2'b00, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00);
    add_vec(0, 2'b00, 0, 0, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    // Core stalls in WAIT_CIPHER: abort exactly 8 cycles after entry
    add_vec(0, 2'b10, 0, 1, 2'b00, 0, 0,  2'b10, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b10, 0, 1, 2'b00, 0, 0,  2'b10, 0, 2'b10, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b10, 0, 1, 2'b10, 0, 0,  2'b10, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 7; k++)
      add_vec(0, 2'b10, 0, 1, 2'b00, 0, 0,  2'b10, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b10, 0, 1, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10);
    add_vec(0, 2'b00, 0, 0, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    // core_end_i while waiting for data is a protocol error
    add_vec(0, 2'b10, 0, 1, 2'b00, 0, 0,  2'b10, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b10, 0, 1, 2'b00, 0, 0,  2'b10, 0, 2'b10, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b10, 0, 1, 2'b00, 0, 1,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10);
    add_vec(0, 2'b00, 0, 0, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    // Normal service afterwards; leaves requester 0 as last owner
    add_vec(0, 2'b01, 1, 0, 2'b00, 0, 0,  2'b01, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 0, 2'b00, 0, 0,  2'b01, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 0, 2'b01, 0, 0,  2'b01, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 0, 2'b00, 1, 0,  2'b01, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00);
    add_vec(0, 2'b01, 1, 0, 2'b00, 0, 1,  2'b00, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00);
    add_vec(0, 2'b00, 0, 0, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);

    #2;
    resetb_i = 1'b0;
    #1;
    check_all_zero("reset state");
    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    resetb_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(i);

    // Asynchronous reset in the middle of a requester-1 transaction
    @(negedge clock_i);
    req_i = 2'b10; nblk_i[1] = 4'd2; data_valid_i = 2'b00;
    core_cipher_valid_i = 1'b0; core_end_i = 1'b0;
    @(posedge clock_i); #1;
    @(posedge clock_i); #1;
    check_val("midreset ready", 128'(data_ready_o), 128'(2'b10));
    @(negedge clock_i);
    data_valid_i = 2'b10;
    @(posedge clock_i); #1;
    check_val("midreset busy", 128'({grant_o, core_data_valid_o}), 128'(3'b101));
    resetb_i = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clock_i);
    resetb_i = 1'b1; req_i = 2'b11; data_valid_i = 2'b00;
    @(posedge clock_i); #1;
    check_val("post-reset tie", 128'({grant_o, core_start_o}), 128'(3'b011));
    check_val("post-reset done/err", 128'({done_o, err_o}), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
